// File: rtl/vga_fetch_pkg.sv
// Shared definitions for the VGA scanout prefetcher: FSM encoding,
// frame-size helper and default framebuffer base address.
package vga_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CAPTURE = 2'd2
    } fetch_state_t;

    localparam logic [15:0] DEF_FB_BASE = 16'h0000;

    // Two RGB332 pixels are packed per 16-bit SPRAM word.
    function automatic logic [16:0] words_per_frame(
        input int unsigned h,
        input int unsigned v
    );
        return 17'((h * v) / 2);
    endfunction

endpackage

// File: rtl/vga_word_fifo.sv
// Synchronous 16-bit word FIFO for the VGA prefetcher.
// Ports: clk, rst (async, active-high), push, pop, flush (wins over
// push/pop), din, dout (head word, valid when count != 0), count.
module vga_word_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [15:0]   din,
    output logic [15:0]   dout,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vga_spram_fetch.sv
// VGA scanout prefetcher: fetches framebuffer words from the SPRAM VGA
// port into a word FIFO and serialises them into RGB332 pixels.
// Ports: I_clk, I_reset (async, active-high), I_frame_start, I_pix_req,
// O_pixel, O_underrun, O_vga_req, O_vga_adr, I_vga_dat, and
// O_underrun_cnt when VGA_FETCH_STATS_EN is defined.
module vga_spram_fetch
    import vga_fetch_pkg::*;
#(
    parameter logic [15:0] FB_BASE    = DEF_FB_BASE,
    parameter int          H_PIXELS   = 320,
    parameter int          V_LINES    = 240,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_frame_start,
    input  logic        I_pix_req,
    output logic [7:0]  O_pixel,
    output logic        O_underrun,
`ifdef VGA_FETCH_STATS_EN
    output logic [15:0] O_underrun_cnt,
`endif
    output logic        O_vga_req,
    output logic [15:0] O_vga_adr,
    input  logic [15:0] I_vga_dat
);

    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [16:0] WPF =
        words_per_frame(H_PIXELS, V_LINES);

    fetch_state_t  state;
    fetch_state_t  state_nxt;
    logic [16:0]   word_cnt;
    logic          byte_hi;
    logic          fifo_push;
    logic          fifo_pop;
    logic [15:0]   fifo_head;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          start_req;
    logic          pop_ok;
    logic          pop_empty;

    assign fifo_empty = (fifo_cnt == '0);
    assign pop_ok     = I_pix_req && !I_frame_start && !fifo_empty;
    assign pop_empty  = I_pix_req && !I_frame_start && fifo_empty;
    // The head word leaves the FIFO only after its low byte is shown.
    assign fifo_pop   = pop_ok && !byte_hi;
    assign fifo_push  = (state == ST_CAPTURE) && !I_frame_start;
    assign O_vga_req  = (state == ST_REQ);

    vga_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (I_clk),
        .rst   (I_reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (I_frame_start),
        .din   (I_vga_dat),
        .dout  (fifo_head),
        .count (fifo_cnt)
    );

    always_comb begin
        state_nxt = state;
        start_req = 1'b0;
        if (I_frame_start) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (word_cnt < WPF && fifo_cnt < CW'(FIFO_DEPTH)) begin
                        state_nxt = ST_REQ;
                        start_req = 1'b1;
                    end
                end
                ST_REQ:     state_nxt = ST_CAPTURE;
                ST_CAPTURE: state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Address is loaded one cycle ahead and then held through CAPTURE
    // because the SPRAM output mux still decodes it in that cycle.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_vga_adr <= FB_BASE;
            word_cnt  <= '0;
        end else begin
            if (start_req) begin
                O_vga_adr <= FB_BASE + word_cnt[15:0];
            end
            if (I_frame_start) begin
                word_cnt <= '0;
            end else if (fifo_push && word_cnt < WPF) begin
                word_cnt <= word_cnt + 17'd1;
            end
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_pixel    <= 8'h00;
            O_underrun <= 1'b0;
            byte_hi    <= 1'b1;
        end else if (I_frame_start) begin
            O_underrun <= 1'b0;
            byte_hi    <= 1'b1;
        end else if (pop_ok) begin
            O_pixel <= byte_hi ? fifo_head[15:8] : fifo_head[7:0];
            byte_hi <= !byte_hi;
        end else if (pop_empty) begin
            O_pixel    <= 8'h00;
            O_underrun <= 1'b1;
        end
    end

`ifdef VGA_FETCH_STATS_EN
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            O_underrun_cnt <= 16'h0000;
        end else if (I_frame_start) begin
            O_underrun_cnt <= 16'h0000;
        end else if (pop_empty && O_underrun_cnt != 16'hFFFF) begin
            O_underrun_cnt <= O_underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_spram_fetch.sv
// Self-checking bench for vga_spram_fetch: a queue-based pixel-stream
// model plus directed vectors with hand-computed expectations.
module tb_vga_spram_fetch;
    import vga_fetch_pkg::*;

    localparam logic [15:0] FB  = 16'h1000;
    localparam int          H   = 32;
    localparam int          V   = 12;
    localparam int          WPF = H * V / 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        pr;
    logic [7:0]  pix;
    logic        und;
    logic        req;
    logic [15:0] adr;
    logic [15:0] dat;
`ifdef VGA_FETCH_STATS_EN
    logic [15:0] ucnt;
`endif

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vga_spram_fetch #(
        .FB_BASE    (FB),
        .H_PIXELS   (H),
        .V_LINES    (V),
        .FIFO_DEPTH (8)
    ) dut (
        .I_clk          (clk),
        .I_reset        (rst),
        .I_frame_start  (fs),
        .I_pix_req      (pr),
        .O_pixel        (pix),
        .O_underrun     (und),
`ifdef VGA_FETCH_STATS_EN
        .O_underrun_cnt (ucnt),
`endif
        .O_vga_req      (req),
        .O_vga_adr      (adr),
        .I_vga_dat      (dat)
    );

    function automatic logic [15:0] spram(input logic [15:0] a);
        if (a == FB) return 16'hA1B2;
        if (a == FB + 16'd1) return 16'hC3D4;
        return {a[7:0] ^ 8'h5A, a[15:8] + a[7:0]};
    endfunction

    assign dat = spram(adr);

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Model: the pixel stream is the byte sequence of the fetched words
    // in address order; a word becomes poppable one cycle after its req.
    logic [15:0] q[$];
    bit          m_hi;
    logic [7:0]  m_pix;
    bit          m_und;
    bit          m_pend;
    logic [15:0] m_pw;
    int          nreq;
    int          m_ucnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_hi = 1; m_pix = 8'h00; m_und = 0;
            m_pend = 0; nreq = 0; m_ucnt = 0;
        end else if (fs) begin
            q.delete();
            m_hi = 1; m_und = 0; m_pend = 0;
            nreq = 0; m_ucnt = 0;
        end else begin
            if (pr) begin
                if (q.size() > 0) begin
                    m_pix = m_hi ? q[0][15:8] : q[0][7:0];
                    if (!m_hi) void'(q.pop_front());
                    m_hi = !m_hi;
                end else begin
                    m_pix = 8'h00;
                    m_und = 1;
                    if (m_ucnt < 65535) m_ucnt++;
                end
            end
            if (m_pend) begin
                q.push_back(m_pw);
                m_pend = 0;
            end
            if (req) begin
                m_pend = 1;
                m_pw = spram(adr);
                nreq++;
            end
        end
    end

    bit          chk_en   = 0;
    bit          prev_req = 0;
    int          cyc      = 0;
    int          last_req = -100;
    logic [15:0] first_adr;
    logic [15:0] last_adr;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("pixel", pix, m_pix);
            chk("underrun", und, m_und);
`ifdef VGA_FETCH_STATS_EN
            chk("underrun_cnt", ucnt, m_ucnt);
`endif
            if (req) begin
                chk("req_adr", adr, FB + nreq[15:0]);
                chk("req_width", prev_req, 0);
                chk("req_in_frame", nreq < WPF, 1);
                if (nreq > 0) chk("req_gap", (cyc - last_req) >= 3, 1);
                if (nreq == 0) first_adr = adr;
                last_adr = adr;
                last_req = cyc;
            end
        end
        prev_req = req;
        cyc++;
    end

    task automatic wait_req();
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = req;
        end
        chk("wait_req", seen, 1);
    endtask

    task automatic pop1();
        pr = 1;
        @(negedge clk);
        pr = 0;
    endtask

    initial begin
        logic [7:0] exp4 [4];
        logic [7:0] saved;
        exp4 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        rst = 1; fs = 0; pr = 0;

        chk("wpf_default", words_per_frame(320, 240), 38400);
        repeat (2) @(negedge clk);
        chk("rst_req", req, 0);
        chk("rst_adr", adr, FB);
        chk("rst_pix", pix, 8'h00);
        chk("rst_und", und, 0);
        rst = 0;
        chk_en = 1;

        // Fill with no pops: 8 requests then stall on a full FIFO.
        fs = 1;
        @(negedge clk);
        fs = 0;
        repeat (40) @(negedge clk);
        chk("fill_nreq", nreq, 8);
        chk("fill_first_adr", first_adr, 16'h1000);
        chk("fill_last_adr", last_adr, 16'h1007);
        chk("fill_req_low", req, 0);

        // First pixels come out high byte first.
        for (int i = 0; i < 4; i++) begin
            pop1();
            chk("pix_seq", pix, exp4[i]);
            @(negedge clk);
        end
        chk("pix_seq_und", und, 0);

        // Whole frame, one pop every second cycle.
        fs = 1;
        @(negedge clk);
        fs = 0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < H * V; i++) begin
            pop1();
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("frame_und", und, 0);
        chk("frame_nreq", nreq, WPF);
        chk("frame_last_adr", last_adr, 16'h10BF);
        chk("frame_req_low", req, 0);

        // Pop before anything is captured.
        fs = 1;
        @(negedge clk);
        fs = 0;
        pop1();
        chk("early_pix", pix, 8'h00);
        chk("early_und", und, 1);
        fs = 1;
        @(negedge clk);
        fs = 0;
        chk("fs_clears_und", und, 0);
`ifdef VGA_FETCH_STATS_EN
        chk("fs_clears_cnt", ucnt, 16'h0000);
`endif

        // Frame start during CAPTURE with a simultaneous pop.
        wait_req();
        @(negedge clk);
        saved = pix;
        fs = 1; pr = 1;
        @(negedge clk);
        fs = 0;
        chk("fs_cap_pix_hold", pix, saved);
        pop1();
        chk("fs_cap_dropped", und, 1);
        chk("fs_cap_req", req, 1);
        chk("fs_cap_adr", adr, 16'h1000);

        // Reset while a request is in flight.
        repeat (8) @(negedge clk);
        pop1();
        chk("pre_rst_pix", pix, 8'hA1);
        wait_req();
        rst = 1;
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_adr", adr, FB);
        chk("mid_rst_pix", pix, 8'h00);
        chk("mid_rst_und", und, 0);
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
